// File: rtl/uart_alu_frame_engine.sv
// uart_alu_frame_engine: framed UART command parser feeding an ALU, with byte-wise result return
module uart_alu_frame_engine #(
  parameter int NB_BYTE = 8,
  parameter int NB_DATA = 16,
  parameter int NB_OP   = 6,
  parameter int TIMEOUT = 50000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_valid,
  input  logic [NB_DATA-1:0] i_result,
  output logic               o_err,
  output logic [1:0]         o_err_code
);
  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int CW = $clog2(N_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic {P_IDLE, P_PAYLOAD} p_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} t_state_t;
  typedef enum logic [1:0] {K_A, K_B, K_OP} kind_t;
  p_state_t p_state, p_next;
  t_state_t t_state, t_next;
  kind_t kind, kind_nx;
  logic [CW-1:0] byte_cnt, k;
  logic [TW-1:0] timer;
  logic [NB_DATA-1:0] shadow, shadow_nx, tx_sr;
  logic tag_ok, tag_hit, last, commit, bad_tag, tmo, ovr;
  // decode the incoming byte, detect frame end / timeout / overrun, and pick next states
  always_comb begin
    tag_ok = i_rx_data == NB_BYTE'('h08) || i_rx_data == NB_BYTE'('h10) || i_rx_data == NB_BYTE'('h20);
    kind_nx = i_rx_data == NB_BYTE'('h20) ? K_OP : i_rx_data == NB_BYTE'('h10) ? K_B : K_A;
    tag_hit = p_state == P_IDLE && i_rx_done && tag_ok;
    last = byte_cnt == (kind == K_OP ? CW'(0) : CW'(N_BYTES - 1));
    shadow_nx = shadow;
    shadow_nx[byte_cnt*NB_BYTE +: NB_BYTE] = i_rx_data;
    commit = p_state == P_PAYLOAD && i_rx_done && last;
    bad_tag = p_state == P_IDLE && i_rx_done && !tag_ok;
    tmo = p_state == P_PAYLOAD && !i_rx_done && timer == TW'(TIMEOUT - 1);
    ovr = o_valid && t_state != T_IDLE;
    p_next = p_state == P_IDLE ? (tag_hit ? P_PAYLOAD : P_IDLE) : (commit || tmo ? P_IDLE : P_PAYLOAD);
    t_next = t_state == T_IDLE ? (o_valid ? T_SEND : T_IDLE) :
             t_state == T_SEND ? T_WAIT :
             !i_tx_done ? T_WAIT : (k == CW'(N_BYTES - 1) ? T_IDLE : T_SEND);
    o_tx_start = t_state == T_SEND;
    o_tx_data = tx_sr[NB_BYTE-1:0];
  end
  // state registers for both FSMs
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      p_state <= P_IDLE;
      t_state <= T_IDLE;
    end else begin
      p_state <= p_next;
      t_state <= t_next;
    end
  end
  // payload assembly into the shadow and atomic commit of a completed frame
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      kind <= K_A;
      byte_cnt <= '0;
      timer <= '0;
      shadow <= '0;
      o_datoA <= '0;
      o_datoB <= '0;
      o_operation <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= commit && kind == K_OP;
      if (tag_hit) begin
        kind <= kind_nx;
        byte_cnt <= '0;
        timer <= '0;
        shadow <= '0;
      end else if (p_state == P_PAYLOAD && i_rx_done) begin
        shadow <= shadow_nx;
        byte_cnt <= byte_cnt + CW'(1);
        timer <= '0;
      end else if (p_state == P_PAYLOAD) begin
        timer <= timer + TW'(1);
      end
      if (commit && kind == K_A) o_datoA <= shadow_nx;
      if (commit && kind == K_B) o_datoB <= shadow_nx;
      if (commit && kind == K_OP) o_operation <= shadow_nx[NB_OP-1:0];
    end
  end
  // result capture and byte-wise shift-out towards the transmitter
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      tx_sr <= '0;
      k <= '0;
    end else if (t_state == T_IDLE && o_valid) begin
      tx_sr <= i_result;
      k <= '0;
    end else if (t_state == T_WAIT && i_tx_done) begin
      tx_sr <= tx_sr >> NB_BYTE;
      k <= k + CW'(1);
    end
  end
  // single error pulse per cycle, overrun beating timeout beating bad tag
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_err <= 1'b0;
      o_err_code <= 2'b00;
    end else begin
      o_err <= ovr || tmo || bad_tag;
      if (ovr || tmo || bad_tag) o_err_code <= ovr ? 2'b11 : tmo ? 2'b10 : 2'b01;
    end
  end
endmodule

// File: tb/tb_uart_alu_frame_engine.sv
// tb_uart_alu_frame_engine: randomized frame traffic checked against a queue-based reference model
module tb_uart_alu_frame_engine;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic i_rst, i_rx_done, i_tx_done, o_tx_start, o_valid, o_err;
  logic [7:0] i_rx_data, o_tx_data;
  logic [15:0] o_datoA, o_datoB, i_result;
  logic [5:0] o_operation;
  logic [1:0] o_err_code;
  int n_vec = 0, n_err = 0, valid_seen = 0, valid_exp = 0, tx_lo = 1, tx_hi = 6;
  logic resp_busy = 1'b0;
  logic [15:0] ref_a = 0, ref_b = 0;
  logic [5:0] ref_op = 0;
  logic [7:0] exp_tx[$];
  logic [1:0] exp_err[$];

  uart_alu_frame_engine #(.NB_BYTE(8), .NB_DATA(16), .NB_OP(6), .TIMEOUT(TO)) dut (
    .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_tx_done(i_tx_done),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_datoA(o_datoA), .o_datoB(o_datoB),
    .o_operation(o_operation), .o_valid(o_valid), .i_result(i_result), .o_err(o_err),
    .o_err_code(o_err_code));

  always #5 clk = ~clk;

  function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [5:0] op);
    return op == 6'd0 ? a + b : op == 6'd1 ? a - b : a ^ {10'd0, op};
  endfunction

  assign i_result = alu(o_datoA, o_datoB, o_operation);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge clk);
    #1;
    i_rx_done = 1'b0;
  endtask

  task automatic frame(input logic [7:0] tag, input logic [15:0] v, input bit ovr);
    logic [15:0] r;
    int n = tag == 8'h20 ? 1 : 2;
    if (ovr) exp_err.push_back(2'b11);
    send_byte(tag);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 3));
      send_byte(v[i*8 +: 8]);
    end
    if (tag == 8'h08) ref_a = v;
    if (tag == 8'h10) ref_b = v;
    if (tag == 8'h20) begin
      ref_op = v[5:0];
      valid_exp++;
      r = alu(ref_a, ref_b, ref_op);
      if (!ovr) begin
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
      end
    end
  endtask

  task automatic check_ops(input string tag);
    @(negedge clk);
    check({tag, "_A"}, 32'(o_datoA), 32'(ref_a));
    check({tag, "_B"}, 32'(o_datoB), 32'(ref_b));
    check({tag, "_OP"}, 32'(o_operation), 32'(ref_op));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 2000; i++) begin
      if (exp_tx.size() == 0 && !resp_busy) break;
      idle(1);
    end
    check("tx_drain", 32'(exp_tx.size()), 32'd0);
    idle(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_A"}, 32'(o_datoA), 32'd0);
    check({tag, "_B"}, 32'(o_datoB), 32'd0);
    check({tag, "_OP"}, 32'(o_operation), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_txs"}, 32'(o_tx_start), 32'd0);
    check({tag, "_txd"}, 32'(o_tx_data), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_code"}, 32'(o_err_code), 32'd0);
  endtask

  // output monitor: valid count, error code order, transmitted byte order
  initial begin
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        if (o_valid) valid_seen++;
        if (o_err) begin
          if (exp_err.size() != 0) check("err_code", 32'(o_err_code), 32'(exp_err.pop_front()));
          else check("err_unexp", 32'(o_err), 32'd0);
        end
        if (o_tx_start) begin
          if (exp_tx.size() != 0) check("tx_byte", 32'(o_tx_data), 32'(exp_tx.pop_front()));
          else check("tx_unexp", 32'(o_tx_start), 32'd0);
        end
      end
    end
  end

  // uart_tx stand-in: acknowledges each started byte after a random delay
  initial begin
    logic [7:0] b;
    int d;
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_start && !i_rst) begin
        resp_busy = 1'b1;
        b = o_tx_data;
        d = $urandom_range(tx_lo, tx_hi);
        repeat (d) begin
          @(negedge clk);
          check("tx_hold", 32'(o_tx_start), 32'd0);
        end
        @(posedge clk);
        #1 i_tx_done = 1'b1;
        @(negedge clk);
        check("tx_stable", 32'(o_tx_data), 32'(b));
        @(posedge clk);
        #1 i_tx_done = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int r;
    i_rst = 1'b1;
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk);
    #1 i_rst = 1'b0;
    idle(1);
    frame(8'h08, 16'h5A5A, 0);
    check_ops("pre_rst");
    send_byte(8'h08);
    send_byte(8'h77);
    #2 i_rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(posedge clk);
    #1 i_rst = 1'b0;
    ref_a = 0;
    ref_b = 0;
    ref_op = 0;
    frame(8'h08, 16'hABCD, 0);
    check_ops("post_rst");

    frame(8'h08, 16'h1234, 0);
    check_ops("t2a");
    frame(8'h10, 16'h0002, 0);
    check_ops("t2b");
    frame(8'h20, 16'h0000, 0);
    @(negedge clk);
    check("t2_valid", 32'(o_valid), 32'd1);
    check("t2_A", 32'(o_datoA), 32'h1234);
    check("t2_B", 32'(o_datoB), 32'h0002);
    check("t2_OP", 32'(o_operation), 32'h00);
    @(negedge clk);
    check("t2_txs", 32'(o_tx_start), 32'd1);
    check("t2_txd0", 32'(o_tx_data), 32'h36);
    check("t2_valid_pulse", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    wait_tx_idle();

    exp_err.push_back(2'b01);
    send_byte(8'h55);
    @(negedge clk);
    check("t3_err", 32'(o_err), 32'd1);
    @(negedge clk);
    check("t3_pulse", 32'(o_err), 32'd0);
    check("t3_code", 32'(o_err_code), 32'h1);
    @(posedge clk);
    #1;
    check_ops("t3");

    send_byte(8'h08);
    send_byte(8'hAA);
    exp_err.push_back(2'b10);
    idle(TO);
    @(negedge clk);
    check("t4_err", 32'(o_err), 32'd1);
    check("t4_code", 32'(o_err_code), 32'h2);
    check("t4_A", 32'(o_datoA), 32'(ref_a));
    @(posedge clk);
    #1;
    frame(8'h08, 16'h2211, 0);
    check_ops("t4");
    check("t4_A2211", 32'(o_datoA), 32'h2211);

    send_byte(8'h10);
    send_byte(8'h55);
    idle(TO - 1);
    send_byte(8'h66);
    ref_b = 16'h6655;
    @(negedge clk);
    check("t6_noerr", 32'(o_err), 32'd0);
    @(posedge clk);
    #1;
    check_ops("t6");

    tx_lo = 30;
    tx_hi = 30;
    frame(8'h20, 16'h0000, 0);
    idle(4);
    frame(8'h20, 16'h0001, 1);
    check_ops("t5");
    wait_tx_idle();
    tx_lo = 1;
    tx_hi = 6;

    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'h08 || b == 8'h10 || b == 8'h20);
        exp_err.push_back(2'b01);
        send_byte(b);
        idle($urandom_range(1, 3));
      end else if (r == 1) begin
        b = r[0] ? 8'h08 : 8'h10;
        b = $urandom_range(0, 2) == 0 ? 8'h20 : b;
        send_byte(b);
        if (b != 8'h20 && $urandom_range(0, 1) == 1) begin
          idle($urandom_range(0, 3));
          send_byte(8'($urandom_range(0, 255)));
        end
        exp_err.push_back(2'b10);
        idle(TO + $urandom_range(0, 3));
      end else if (r <= 4) begin
        frame(8'h08, 16'($urandom_range(0, 65535)), 0);
      end else if (r <= 7) begin
        frame(8'h10, 16'($urandom_range(0, 65535)), 0);
      end else begin
        wait_tx_idle();
        frame(8'h20, 16'($urandom_range(0, 63)), 0);
      end
      check_ops("rnd");
    end
    wait_tx_idle();
    idle(4);
    check("valid_count", 32'(valid_seen), 32'(valid_exp));
    check("err_missing", 32'(exp_err.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
